// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and shared-memory handshakes of the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [3:0]        dm_be_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_gnt_o;
  logic              dm_rvalid_o;
  logic [DATA_W-1:0] dm_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              stall_if_o;
  logic              stall_dm_o;
  logic              err_o;

  // Arbiter side
  modport master (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    input  mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output stall_if_o, stall_dm_o, err_o
  );

  // Requesters plus memory wrapper side
  modport slave (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
    output mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  stall_if_o, stall_dm_o, err_o
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating counter tracking how many times a waiting fetch lost to the load/store stage.
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != W'(MAX))) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign sat_o = (cnt_q == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store with one outstanding
// transaction, response routing, starvation protection and a response timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              STARVE_MAX = 4,
  parameter int              TIMEOUT    = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input logic                clk_i,
  input logic                rst_i,
  mem_port_arbiter_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  arb_state_t state_q, state_d;
  owner_t     owner;
  logic [TW-1:0] to_cnt_q;

  logic busy, rsp, timeout, arb_en, starve_sat, if_win, dm_win;

  logic              if_gnt, dm_gnt, if_rvalid, dm_rvalid, err;
  logic [DATA_W-1:0] rsp_data;
  logic              mem_req, mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign busy    = (state_q != IDLE);
  assign rsp     = busy && bus.mem_rvalid_i;
  assign timeout = busy && !bus.mem_rvalid_i && (to_cnt_q == TW'(TIMEOUT - 1));
  assign owner   = (state_q == BUSY_DM) ? OWN_DM : OWN_IF;

  // A completing transaction frees the port in the same cycle, so the next winner
  // is picked then; a timeout cycle never issues.
  assign arb_en = !rst_i && ((state_q == IDLE) || rsp);
  assign if_win = arb_en && bus.if_req_i && (!bus.dm_req_i || starve_sat);
  assign dm_win = arb_en && bus.dm_req_i && !if_win;

  arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bus.if_req_i && dm_win),
    .clr_i (if_win || !bus.if_req_i),
    .sat_o (starve_sat)
  );

  // State register and timeout counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (if_win || dm_win || timeout) begin
        to_cnt_q <= '0;
      end else if (busy && !bus.mem_rvalid_i) begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end
    end
  end

  // Next state, response routing and command mux
  always_comb begin
    state_d   = state_q;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    err       = 1'b0;
    rsp_data  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;

    if (rsp || timeout) begin
      rsp_data  = timeout ? ERR_DATA : bus.mem_rdata_i;
      if_rvalid = (owner == OWN_IF);
      dm_rvalid = (owner == OWN_DM);
      err       = timeout;
      state_d   = IDLE;
    end

    if (if_win) begin
      if_gnt   = 1'b1;
      mem_req  = 1'b1;
      mem_addr = bus.if_addr_i;
      state_d  = BUSY_IF;
    end else if (dm_win) begin
      dm_gnt    = 1'b1;
      mem_req   = 1'b1;
      mem_we    = bus.dm_we_i;
      mem_be    = bus.dm_be_i;
      mem_addr  = bus.dm_addr_i;
      mem_wdata = bus.dm_wdata_i;
      state_d   = BUSY_DM;
    end
  end

  assign bus.if_gnt_o    = if_gnt;
  assign bus.if_rvalid_o = if_rvalid;
  assign bus.if_rdata_o  = if_rvalid ? rsp_data : '0;
  assign bus.dm_gnt_o    = dm_gnt;
  assign bus.dm_rvalid_o = dm_rvalid;
  assign bus.dm_rdata_o  = dm_rvalid ? rsp_data : '0;
  assign bus.mem_req_o   = mem_req;
  assign bus.mem_we_o    = mem_we;
  assign bus.mem_be_o    = mem_be;
  assign bus.mem_addr_o  = mem_addr;
  assign bus.mem_wdata_o = mem_wdata;
  assign bus.err_o       = err;

  // Stalls are held low while reset is asserted so every output reads zero.
  assign bus.stall_if_o = !rst_i && bus.if_req_i && !if_rvalid;
  assign bus.stall_dm_o = !rst_i && bus.dm_req_i && !dm_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed per-cycle vector bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  typedef struct {
    string       name;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [3:0]  e_mem_be;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_if_rvalid;
    logic        e_dm_rvalid;
    logic [31:0] e_rdata;
    logic        e_stall_if;
    logic        e_stall_dm;
    logic        e_err;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  vec_t vecs[$];
  vec_t v;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input string nm,
    input logic ifr, input logic [31:0] ifa,
    input logic dmr, input logic we, input logic [3:0] be,
    input logic [31:0] dma, input logic [31:0] wd,
    input logic mv, input logic [31:0] md,
    input logic eig, input logic edg, input logic emr, input logic emw,
    input logic [3:0] emb, input logic [31:0] ema, input logic [31:0] emwd,
    input logic eir, input logic edr, input logic [31:0] erd,
    input logic esi, input logic esd, input logic eerr);
    vec_t r;
    r.name = nm;
    r.if_req = ifr;  r.if_addr = ifa;
    r.dm_req = dmr;  r.dm_we = we;  r.dm_be = be;  r.dm_addr = dma;  r.dm_wdata = wd;
    r.mem_rvalid = mv;  r.mem_rdata = md;
    r.e_if_gnt = eig;  r.e_dm_gnt = edg;  r.e_mem_req = emr;  r.e_mem_we = emw;
    r.e_mem_be = emb;  r.e_mem_addr = ema;  r.e_mem_wdata = emwd;
    r.e_if_rvalid = eir;  r.e_dm_rvalid = edr;  r.e_rdata = erd;
    r.e_stall_if = esi;  r.e_stall_dm = esd;  r.e_err = eerr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t s);
    bus.if_req_i     = s.if_req;
    bus.if_addr_i    = s.if_addr;
    bus.dm_req_i     = s.dm_req;
    bus.dm_we_i      = s.dm_we;
    bus.dm_be_i      = s.dm_be;
    bus.dm_addr_i    = s.dm_addr;
    bus.dm_wdata_i   = s.dm_wdata;
    bus.mem_rvalid_i = s.mem_rvalid;
    bus.mem_rdata_i  = s.mem_rdata;
  endtask

  task automatic checkOutput(input vec_t s);
    chk({s.name, ".if_gnt"},    32'(bus.if_gnt_o),    32'(s.e_if_gnt));
    chk({s.name, ".dm_gnt"},    32'(bus.dm_gnt_o),    32'(s.e_dm_gnt));
    chk({s.name, ".mem_req"},   32'(bus.mem_req_o),   32'(s.e_mem_req));
    chk({s.name, ".mem_we"},    32'(bus.mem_we_o),    32'(s.e_mem_we));
    chk({s.name, ".mem_be"},    32'(bus.mem_be_o),    32'(s.e_mem_be));
    chk({s.name, ".mem_addr"},  bus.mem_addr_o,       s.e_mem_addr);
    if (!s.e_if_gnt)
      chk({s.name, ".mem_wdata"}, bus.mem_wdata_o,    s.e_mem_wdata);
    chk({s.name, ".if_rvalid"}, 32'(bus.if_rvalid_o), 32'(s.e_if_rvalid));
    if (s.e_if_rvalid)
      chk({s.name, ".if_rdata"}, bus.if_rdata_o,      s.e_rdata);
    chk({s.name, ".dm_rvalid"}, 32'(bus.dm_rvalid_o), 32'(s.e_dm_rvalid));
    if (s.e_dm_rvalid)
      chk({s.name, ".dm_rdata"}, bus.dm_rdata_o,      s.e_rdata);
    chk({s.name, ".stall_if"},  32'(bus.stall_if_o),  32'(s.e_stall_if));
    chk({s.name, ".stall_dm"},  32'(bus.stall_dm_o),  32'(s.e_stall_dm));
    chk({s.name, ".err"},       32'(bus.err_o),       32'(s.e_err));
  endtask

  // One clock cycle: drive just after the edge, check on the falling edge.
  task automatic runCycle(input vec_t s);
    applyStimulus(s);
    @(negedge clk);
    checkOutput(s);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;

    //             name                  ifr ifa     dmr we be      dma       wd            mv md             | ig dg mr mw mb      ma        mwd           | ir dr rd            | si sd er
    vecs.push_back(mk("if_rd_gnt",        1, 32'h10, 0, 0, 4'h0,   32'h0,    32'h0,        0, 32'h0,          1, 0, 1, 0, 4'h0,   32'h10,   32'h0,        0, 0, 32'h0,          1, 0, 0));
    vecs.push_back(mk("if_rd_wait",       1, 32'h10, 0, 0, 4'h0,   32'h0,    32'h0,        0, 32'h0,          0, 0, 0, 0, 4'h0,   32'h0,    32'h0,        0, 0, 32'h0,          1, 0, 0));
    vecs.push_back(mk("if_rsp_b2b",       1, 32'h14, 0, 0, 4'h0,   32'h0,    32'h0,        1, 32'h13,         1, 0, 1, 0, 4'h0,   32'h14,   32'h0,        1, 0, 32'h13,         0, 0, 0));
    vecs.push_back(mk("if_b2b_wait",      1, 32'h14, 0, 0, 4'h0,   32'h0,    32'h0,        0, 32'h0,          0, 0, 0, 0, 4'h0,   32'h0,    32'h0,        0, 0, 32'h0,          1, 0, 0));
    vecs.push_back(mk("if_b2b_rsp",       0, 32'h0,  0, 0, 4'h0,   32'h0,    32'h0,        1, 32'h17,         0, 0, 0, 0, 4'h0,   32'h0,    32'h0,        1, 0, 32'h17,         0, 0, 0));
    vecs.push_back(mk("both_dm_first",    1, 32'h20, 1, 0, 4'hF,   32'h1000, 32'h0,        0, 32'h0,          0, 1, 1, 0, 4'hF,   32'h1000, 32'h0,        0, 0, 32'h0,          1, 1, 0));
    vecs.push_back(mk("both_wait",        1, 32'h20, 1, 0, 4'hF,   32'h1000, 32'h0,        0, 32'h0,          0, 0, 0, 0, 4'h0,   32'h0,    32'h0,        0, 0, 32'h0,          1, 1, 0));
    vecs.push_back(mk("dm_rsp_if_gnt",    1, 32'h20, 0, 0, 4'h0,   32'h0,    32'h0,        1, 32'hCAFE0001,   1, 0, 1, 0, 4'h0,   32'h20,   32'h0,        0, 1, 32'hCAFE0001,   1, 0, 0));
    vecs.push_back(mk("if_after_dm_wait", 1, 32'h20, 0, 0, 4'h0,   32'h0,    32'h0,        0, 32'h0,          0, 0, 0, 0, 4'h0,   32'h0,    32'h0,        0, 0, 32'h0,          1, 0, 0));
    vecs.push_back(mk("if_after_dm_rsp",  0, 32'h0,  0, 0, 4'h0,   32'h0,    32'h0,        1, 32'h21,         0, 0, 0, 0, 4'h0,   32'h0,    32'h0,        1, 0, 32'h21,         0, 0, 0));
    vecs.push_back(mk("starve_dm1",       1, 32'h40, 1, 0, 4'hF,   32'h3000, 32'h0,        0, 32'h0,          0, 1, 1, 0, 4'hF,   32'h3000, 32'h0,        0, 0, 32'h0,          1, 1, 0));
    vecs.push_back(mk("starve_dm2",       1, 32'h40, 1, 0, 4'hF,   32'h3004, 32'h0,        1, 32'h11,         0, 1, 1, 0, 4'hF,   32'h3004, 32'h0,        0, 1, 32'h11,         1, 0, 0));
    vecs.push_back(mk("starve_dm3",       1, 32'h40, 1, 0, 4'hF,   32'h3008, 32'h0,        1, 32'h12,         0, 1, 1, 0, 4'hF,   32'h3008, 32'h0,        0, 1, 32'h12,         1, 0, 0));
    vecs.push_back(mk("starve_dm4",       1, 32'h40, 1, 0, 4'hF,   32'h300C, 32'h0,        1, 32'h13,         0, 1, 1, 0, 4'hF,   32'h300C, 32'h0,        0, 1, 32'h13,         1, 0, 0));
    vecs.push_back(mk("starve_if_wins",   1, 32'h40, 1, 0, 4'hF,   32'h3010, 32'h0,        1, 32'h14,         1, 0, 1, 0, 4'h0,   32'h40,   32'h0,        0, 1, 32'h14,         1, 0, 0));
    vecs.push_back(mk("starve_cleared",   1, 32'h44, 1, 0, 4'hF,   32'h3010, 32'h0,        1, 32'h41,         0, 1, 1, 0, 4'hF,   32'h3010, 32'h0,        1, 0, 32'h41,         0, 1, 0));
    vecs.push_back(mk("dm_drain",         0, 32'h0,  0, 0, 4'h0,   32'h0,    32'h0,        1, 32'h15,         0, 0, 0, 0, 4'h0,   32'h0,    32'h0,        0, 1, 32'h15,         0, 0, 0));
    vecs.push_back(mk("store_gnt",        0, 32'h0,  1, 1, 4'b0011, 32'h2000, 32'hA5A5A5A5, 0, 32'h0,         0, 1, 1, 1, 4'b0011, 32'h2000, 32'hA5A5A5A5, 0, 0, 32'h0,          0, 1, 0));
    vecs.push_back(mk("store_wait",       0, 32'h0,  1, 1, 4'b0011, 32'h2000, 32'hA5A5A5A5, 0, 32'h0,         0, 0, 0, 0, 4'h0,   32'h0,    32'h0,        0, 0, 32'h0,          0, 1, 0));
    vecs.push_back(mk("store_ack",        0, 32'h0,  0, 0, 4'h0,   32'h0,    32'h0,        1, 32'h0BAD0000,   0, 0, 0, 0, 4'h0,   32'h0,    32'h0,        0, 1, 32'h0BAD0000,   0, 0, 0));
    vecs.push_back(mk("stale_rvalid_idle",0, 32'h0,  0, 0, 4'h0,   32'h0,    32'h0,        1, 32'h99,         0, 0, 0, 0, 4'h0,   32'h0,    32'h0,        0, 0, 32'h0,          0, 0, 0));

    // Reset state
    rst = 1'b1;
    applyStimulus(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput(mk("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      runCycle(vecs[i]);
    end

    // Memory never answers a DM load: 16th busy cycle times out.
    runCycle(mk("to_gnt", 0, 0, 1, 0, 4'hF, 32'h5000, 0, 0, 0,
                0, 1, 1, 0, 4'hF, 32'h5000, 0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 15; k++) begin
      runCycle(mk("to_wait", 0, 0, 1, 0, 4'hF, 32'h5000, 0, 0, 0,
                  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    end
    runCycle(mk("to_fire", 0, 0, 1, 0, 4'hF, 32'h5000, 0, 0, 0,
                0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1));
    runCycle(mk("to_late_rsp", 0, 0, 0, 0, 0, 0, 0, 1, 32'h77,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset in the middle of a DM transaction.
    runCycle(mk("rst_pre_gnt", 0, 0, 1, 0, 4'hF, 32'h6000, 0, 0, 0,
                0, 1, 1, 0, 4'hF, 32'h6000, 0, 0, 0, 0, 0, 1, 0));
    rst = 1'b1;
    v = mk("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(v);
    #1;
    checkOutput(v);
    @(negedge clk);
    v = mk("rst_rsp_dropped", 0, 0, 0, 0, 0, 0, 0, 1, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(v);
    #1;
    checkOutput(v);
    @(posedge clk);
    #1;
    rst = 1'b0;
    runCycle(mk("rst_stale_rsp", 0, 0, 0, 0, 0, 0, 0, 1, 32'h66,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    runCycle(mk("rst_if_gnt", 1, 32'h80, 0, 0, 0, 0, 0, 0, 0,
                1, 0, 1, 0, 0, 32'h80, 0, 0, 0, 0, 1, 0, 0));
    runCycle(mk("rst_if_rsp", 0, 0, 0, 0, 0, 0, 0, 1, 32'h81,
                0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h81, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified instruction/data memory between two requesters: instruction fetch (IF) and the load/store stage (DM). Allows one outstanding memory transaction at a time and routes each response to the requester that issued it. Produces per-requester stall signals that gate the PC enable and pipeline-register enables. Sits between the fetch/memory stages and a shared memory wrapper.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, consecutive DM-won cycles after which a waiting IF request is forced to win
TIMEOUT, 16, cycles without mem_rvalid_i before the transaction is aborted
ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
if_req_i  in  1  fetch request (read only)
if_addr_i  in  ADDR_W  fetch address
if_gnt_o  out  1  fetch request accepted this cycle
if_rvalid_o  out  1  one-cycle fetch response pulse
if_rdata_o  out  DATA_W  fetch response data
dm_req_i  in  1  load/store request
dm_we_i  in  1  1 = store
dm_be_i  in  4  store byte enables
dm_addr_i  in  ADDR_W  load/store address
dm_wdata_i  in  DATA_W  store data
dm_gnt_o  out  1  DM request accepted this cycle
dm_rvalid_o  out  1  one-cycle DM response pulse (load data or store ack)
dm_rdata_o  out  DATA_W  load data
mem_req_o  out  1  memory command strobe
mem_we_o  out  1  memory write
mem_be_o  out  4  memory byte enables
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rvalid_i  in  1  memory completion (reads and writes)
mem_rdata_i  in  DATA_W  memory read data
stall_if_o  out  1  freeze fetch
stall_dm_o  out  1  freeze the load/store stage and all earlier stages
err_o  out  1  one-cycle timeout pulse

Behaviour:
- FSM states: IDLE, BUSY_IF, BUSY_DM. Reset: IDLE, starve_cnt=0, timeout_cnt=0, all outputs 0.
- Arbitration is combinational. It happens in IDLE, and in a BUSY state during the cycle mem_rvalid_i=1 (back-to-back issue).
  - Both requests present: DM wins unless starve_cnt==STARVE_MAX, in which case IF wins.
  - Single request wins.
  - Winner: gnt_o=1, mem_req_o=1. mem_* mirrors the winner's inputs in the same cycle. IF forces we=0, be=4'b0000.
  - Next state: BUSY_IF or BUSY_DM. Otherwise next state is IDLE.
- mem_req_o is 0 in BUSY cycles where no arbitration occurs. mem_* data/address outputs are 0 when mem_req_o=0.
- Requesters hold req/addr/data stable until gnt and may drop req afterwards. Exactly one gnt per accepted request.
- Response routing: in BUSY_x with mem_rvalid_i=1, owner's rvalid_o=1 for one cycle and rdata_o=mem_rdata_i. For DM stores, rdata is don't-care (drive mem_rdata_i). Non-owner rvalid stays 0.
- mem_rvalid_i in IDLE (stale response after reset or timeout) is ignored: no pulse, no error.
- starve_cnt:
  - +1 (saturating at STARVE_MAX) each cycle if_req_i=1 and DM is granted.
  - Cleared when IF is granted or if_req_i=0.
  - Held otherwise.
- timeout_cnt: cleared on every grant, +1 each BUSY cycle without mem_rvalid_i. When it reaches TIMEOUT-1 without response:
  - owner's rvalid_o=1 with rdata_o=ERR_DATA, err_o=1
  - next state IDLE; no arbitration that cycle
- Stalls (combinational):
  - stall_if_o = if_req_i & ~if_rvalid_o
  - stall_dm_o = dm_req_i & ~dm_rvalid_o
  - Requester keeps req high from issue until its rvalid.
- Minimum latency: request to rvalid = memory latency + 0 arbiter cycles. Throughput: one transaction per memory latency.
- Reset asserted mid-transaction: immediate return to IDLE. The in-flight response is dropped per the IDLE rule.

Decomposition:
- Package mem_arb_pkg: arb_state_t enum {IDLE, BUSY_IF, BUSY_DM}, owner_t enum {OWN_IF, OWN_DM}, ERR_DATA default constant.
- One sub-module, arb_starve_ctr: saturating counter with inc/clr inputs and a sat output. FSM and routing stay in the top module.

Test Plan:
- IF read 0x0000_0010, memory latency 2, rdata 0x0000_0013 -> if_gnt_o in cycle 0, mem_req_o=1 with addr 0x10 and we=0, if_rvalid_o with 0x13 in cycle 2, stall_if_o high in cycles 0-1 and low in cycle 2.
- if_req and dm load 0x1000 in the same cycle, starve_cnt=0 -> DM granted first; IF granted in the DM rvalid cycle (back-to-back); starve_cnt was 1 then clears.
- DM requests continuously, IF held high -> after 4 DM grants, starve_cnt=4 and the 5th grant goes to IF; counter clears.
- DM store addr 0x2000, wdata 0xA5A5_A5A5, be 4'b0011 -> mem_we_o=1 and mem_be_o=4'b0011 mirrored in the grant cycle; dm_rvalid_o pulses on the memory ack; if_rvalid_o stays 0.
- Memory never responds -> at BUSY cycle 15: err_o=1, owner rvalid with 0xDEAD_BEEF, FSM to IDLE; a late mem_rvalid_i is ignored.
- rst_i asserted in BUSY_DM -> all outputs 0 immediately; the subsequent mem_rvalid_i produces no pulse; a new IF request is granted normally after release.
